// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register map, dither width and the
// rule that picks which fine-duty bit stretches a given period by one clock.
package pwm_bank_pkg;

  localparam logic [19:0] CTRL        = 20'h00000;
  localparam logic [19:0] CH_BASE     = 20'h00020;
  localparam int          DITHER_BITS = 4;

  // Spreads the 4 fine bits over a 16-period cycle: fine[3] fires in 8
  // periods, fine[2] in 4, fine[1] in 2, fine[0] in 1, and ph 0 never fires.
  function automatic logic ext_sel(input logic [DITHER_BITS-1:0] fine,
                                   input logic [DITHER_BITS-1:0] ph_next);
    if (ph_next[0])                return fine[3];
    else if (ph_next[1:0] == 2'b10)  return fine[2];
    else if (ph_next[2:0] == 3'b100) return fine[1];
    else if (ph_next == 4'b1000)   return fine[0];
    else                           return 1'b0;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_ch.sv
// One PWM channel: picks its duty source, applies dither, latches the
// active duty at the period boundary and compares it against the counter.
module red_pitaya_pwm_ch
  import pwm_bank_pkg::*;
#(
  parameter int DW       = 14,
  parameter int PWM_BITS = 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [DW-1:0]                   hw,
  input  logic [PWM_BITS+DITHER_BITS-1:0] val,
  input  logic                            en,
  input  logic                            src,
  input  logic                            bnd,
  input  logic [DITHER_BITS-1:0]          ph_next,
  input  logic [PWM_BITS-1:0]             cnt,
  output logic                            pwm
);

  localparam int VW = PWM_BITS + DITHER_BITS;

  logic [DW-1:0]     hw_q;
  logic [DW-1:0]     conv;
  logic [VW-1:0]     sel;
  logic              ext;
  logic [PWM_BITS:0] duty;
  logic [PWM_BITS:0] duty_nxt;
  logic              unused_conv;

  // Flipping the sign bit turns two's complement into offset binary, so the
  // most negative input maps to 0 and the most positive to all ones.
  assign conv        = {~hw_q[DW-1], hw_q[DW-2:0]};
  assign sel         = src ? conv[DW-1 -: VW] : val;
  assign ext         = ext_sel(sel[DITHER_BITS-1:0], ph_next);
  assign duty_nxt    = {1'b0, sel[VW-1 -: PWM_BITS]} + {{PWM_BITS{1'b0}}, ext};
  assign unused_conv = ^conv;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hw_q <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      hw_q <= hw;
      if (bnd) duty <= en ? duty_nxt : '0;
      pwm <= ({1'b0, cnt} < duty);
    end
  end

endmodule

// File: rtl/red_pitaya_pwm_bank.sv
// Bank of dithered PWM outputs with a shared period/phase counter and a
// simple system-bus register file (CTRL plus one value register per channel).
module red_pitaya_pwm_bank #(
  parameter int NCH         = 4,
  parameter int DW          = 14,
  parameter int PWM_BITS    = 8,
  parameter int DITHER_BITS = pwm_bank_pkg::DITHER_BITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NCH*DW-1:0]   pwm_i,
  output logic [NCH-1:0]      pwm_o,
  input  logic [31:0]         sys_addr,
  input  logic [31:0]         sys_wdata,
  input  logic [3:0]          sys_sel,
  input  logic                sys_wen,
  input  logic                sys_ren,
  output logic [31:0]         sys_rdata,
  output logic                sys_err,
  output logic                sys_ack
);

  localparam int                  VW      = PWM_BITS + DITHER_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0]    cnt;
  logic [DITHER_BITS-1:0] ph;
  logic [DITHER_BITS-1:0] ph_next;
  logic                   bnd;

  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] src_q, src_d;
  logic [VW-1:0]  val_q [NCH];
  logic [VW-1:0]  val_d [NCH];

  logic [19:0] addr;
  logic        ctrl_hit;
  logic        ch_hit;
  logic [2:0]  ch_idx;
  logic [31:0] rdata_d;
  logic        unused_bus;

  assign addr       = sys_addr[19:0];
  assign ch_idx     = addr[4:2];
  assign ctrl_hit   = (addr == pwm_bank_pkg::CTRL);
  assign ch_hit     = (addr[19:5] == pwm_bank_pkg::CH_BASE[19:5]) && (addr[1:0] == 2'b00)
                      && ({29'd0, ch_idx} < NCH);
  assign unused_bus = ^{sys_sel, sys_addr, sys_wdata};
  assign sys_err    = 1'b0;

  assign bnd     = (cnt == CNT_MAX);
  assign ph_next = ph + 1'b1;

  // Channels see the post-write register view, so a write landing on the
  // boundary cycle already shapes the period that begins there.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    en_d  = en_q;
    src_d = src_q;
    for (int k = 0; k < NCH; k++) val_d[k] = val_q[k];
    if (sys_wen) begin
      if (ctrl_hit) begin
        en_d  = sys_wdata[NCH-1:0];
        src_d = sys_wdata[16 +: NCH];
      end else if (ch_hit) begin
        for (int k = 0; k < NCH; k++)
          if (ch_idx == 3'(k)) val_d[k] = sys_wdata[VW-1:0];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (ctrl_hit) begin
      rdata_d[NCH-1:0]   = en_q;
      rdata_d[16 +: NCH] = src_q;
    end else if (ch_hit) begin
      for (int k = 0; k < NCH; k++)
        if (ch_idx == 3'(k)) rdata_d[VW-1:0] = val_q[k];
    end
  end

  // NOTE: the value registers form a small array but are architecturally
  // visible state, so each entry is cleared on reset like any other flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q  <= '0;
      src_q <= '0;
      for (int k = 0; k < NCH; k++) val_q[k] <= '0;
    end else begin
      en_q  <= en_d;
      src_q <= src_d;
      for (int k = 0; k < NCH; k++) val_q[k] <= val_d[k];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) sys_rdata <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      ph  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (bnd) ph <= ph_next;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    red_pitaya_pwm_ch #(
      .DW       (DW),
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .hw      (pwm_i[k*DW +: DW]),
      .val     (val_d[k]),
      .en      (en_d[k]),
      .src     (src_d[k]),
      .bnd     (bnd),
      .ph_next (ph_next),
      .cnt     (cnt),
      .pwm     (pwm_o[k])
    );
  end

endmodule

// File: tb/tb_red_pitaya_pwm_bank.sv
// Directed bench for the PWM bank: bus access, duty/dither high counts per
// period, hardware source conversion, boundary timing and async reset.
module tb_red_pitaya_pwm_bank;

  localparam int NCH = 4;
  localparam int DW  = 14;

  logic              clk = 1'b0;
  logic              rstn_i = 1'b0;
  logic [NCH*DW-1:0] pwm_i = '0;
  logic [NCH-1:0]    pwm_o;
  logic [31:0]       sys_addr = '0;
  logic [31:0]       sys_wdata = '0;
  logic [3:0]        sys_sel = 4'hF;
  logic              sys_wen = 1'b0;
  logic              sys_ren = 1'b0;
  logic [31:0]       sys_rdata;
  logic              sys_err;
  logic              sys_ack;

  int total = 0;
  int bad   = 0;
  int cyc;

  red_pitaya_pwm_bank #(.NCH(NCH), .DW(DW), .PWM_BITS(8)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .pwm_i     (pwm_i),
    .pwm_o     (pwm_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  always #5 clk = ~clk;

  // Bench-owned clock count since reset release; period p covers samples
  // taken after edges 256p+1 .. 256p+256.
  always @(posedge clk or negedge rstn_i)
    if (!rstn_i) cyc <= 0;
    else         cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
    chk("wr_ack", {31'd0, sys_ack}, 32'd1);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sys_addr = a;
    sys_ren  = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    chk({tag, "_ack"}, {31'd0, sys_ack}, 32'd1);
    chk(tag, sys_rdata, exp);
  endtask

  task automatic wait_boundary();
    repeat (2) @(negedge clk);
    while (cyc % 256 != 0) @(negedge clk);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (256) begin
      @(negedge clk);
      h0 += int'(pwm_o[0]);
      h1 += int'(pwm_o[1]);
    end
  endtask

  initial begin
    int h0, h1, p, exp_hi, sum;

    // Reset state
    #1;
    chk("rst_pwm", {28'd0, pwm_o}, 32'd0);
    chk("rst_ack", {31'd0, sys_ack}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_rdata", sys_rdata, 32'd0);
    chk("rst_err", {31'd0, sys_err}, 32'd0);
    rstn_i = 1'b1;
    bus_read("rd_val0_rst", 32'h20, 32'h0);
    bus_read("rd_ctrl_rst", 32'h00, 32'h0);

    // 50% duty, no dither
    bus_write(32'h20, 32'h800);
    bus_write(32'h00, 32'h1);
    bus_read("rd_val0", 32'h20, 32'h800);
    bus_read("rd_ctrl", 32'h00, 32'h1);
    wait_boundary();
    measure(h0, h1);
    chk("half_p0", h0, 128);
    measure(h0, h1);
    chk("half_p1", h0, 128);
    chk("ch1_off", h1, 0);

    // fine[0] set: only the ph=8 period gets the extra clock
    bus_write(32'h20, 32'h801);
    wait_boundary();
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      p = (cyc / 256) % 16;
      exp_hi = (p == 8) ? 129 : 128;
      measure(h0, h1);
      sum += h0;
      chk($sformatf("dither_ph%0d", p), h0, exp_hi);
    end
    chk("dither_total", sum, 2049);

    // Hardware source: most negative input gives zero duty
    pwm_i[13:0] = 14'h2000;
    bus_write(32'h00, 32'h10001);
    wait_boundary();
    measure(h0, h1);
    chk("hw_min", h0, 0);

    // Most positive input: 255 at ph=0, fully high elsewhere
    pwm_i[13:0] = 14'h1FFF;
    wait_boundary();
    for (int i = 0; i < 16; i++) begin
      p = (cyc / 256) % 16;
      exp_hi = (p == 0) ? 255 : 256;
      measure(h0, h1);
      chk($sformatf("hw_max_ph%0d", p), h0, exp_hi);
    end

    // Mid-period write: current period keeps the old duty
    bus_write(32'h00, 32'h1);
    bus_write(32'h20, 32'h400);
    wait_boundary();
    measure(h0, h1);
    chk("pre_mid_wr", h0, 64);
    h0 = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 50) begin
        sys_addr  = 32'h20;
        sys_wdata = 32'hC00;
        sys_wen   = 1'b1;
      end
      @(negedge clk);
      h0 += int'(pwm_o[0]);
      if (i == 50) begin
        sys_wen = 1'b0;
        chk("mid_wr_ack", {31'd0, sys_ack}, 32'd1);
      end
    end
    chk("mid_wr_same_period", h0, 64);
    measure(h0, h1);
    chk("mid_wr_next_period", h0, 192);

    // Second channel and disable
    bus_write(32'h24, 32'h100);
    bus_write(32'h00, 32'h3);
    wait_boundary();
    measure(h0, h1);
    chk("two_ch_ch0", h0, 192);
    chk("two_ch_ch1", h1, 16);
    bus_write(32'h00, 32'h0);
    wait_boundary();
    measure(h0, h1);
    chk("disabled_ch0", h0, 0);
    chk("disabled_ch1", h1, 0);

    // Unmapped / out-of-range accesses
    bus_read("rd_unmapped", 32'h1000, 32'h0);
    chk("err_unmapped", {31'd0, sys_err}, 32'd0);
    bus_write(32'h20 + 4 * NCH, 32'hFFF);
    chk("err_oor_wr", {31'd0, sys_err}, 32'd0);
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, sys_ack}, 32'd0);
    bus_read("rd_oor", 32'h20 + 4 * NCH, 32'h0);
    bus_read("rd_val0_kept", 32'h20, 32'hC00);
    bus_read("rd_val1_kept", 32'h24, 32'h100);
    bus_read("rd_ctrl_kept", 32'h00, 32'h0);

    // Asynchronous reset mid-period
    bus_write(32'h00, 32'h1);
    wait_boundary();
    repeat (10) @(negedge clk);
    chk("pre_rst_high", {31'd0, pwm_o[0]}, 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("async_rst_pwm", {28'd0, pwm_o}, 32'd0);
    chk("async_rst_ack", {31'd0, sys_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    measure(h0, h1);
    chk("post_rst_no_pulse", h0, 0);
    bus_read("rd_val0_post_rst", 32'h20, 32'h0);
    bus_read("rd_ctrl_post_rst", 32'h00, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/red_pitaya_pwm_bank.md
RED_PITAYA_PWM_BANK -- requirements
Module: red_pitaya_pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PWM channels (1..8).
REQ-002 SHALL have parameter DW, default 14, width of each signed hardware input (DW >= 12).
REQ-003 SHALL have parameter PWM_BITS, default 8, coarse duty width; period is 2**PWM_BITS clocks.
REQ-004 SHALL have parameter DITHER_BITS, fixed 4, fine duty width; dither sequence is 16 periods.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rstn_i, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port pwm_i, input, NCH*DW; signed hardware duty inputs, with channel k at bits [k*DW +: DW].
REQ-008 SHALL have port pwm_o, output, NCH; PWM outputs.
REQ-009 SHALL have ports sys_addr (input, 32), sys_wdata (input, 32), sys_sel (input, 4), sys_wen (input, 1), sys_ren (input, 1), sys_rdata (output, 32), sys_err (output, 1) and sys_ack (output, 1), forming the system bus.

Function
REQ-010 SHALL decode sys_addr[19:0]; the CTRL register at 0x00 holds enable in [NCH-1:0] and source select in [16+NCH-1:16], where 0 selects the register and 1 selects pwm_i.
REQ-011 SHALL provide channel value register k at 0x20+4k, with width PWM_BITS+4, as unsigned {coarse, fine}.
REQ-012 SHALL treat all writes as full-word: sys_sel is ignored and unused high bits are dropped.
REQ-013 SHALL ignore writes to channel index >= NCH or to unmapped addresses, and return 0 on reads of them.
REQ-014 SHALL assert sys_ack exactly one cycle after any cycle with sys_wen|sys_ren, for every address; sys_err SHALL be constant 0.
REQ-015 SHALL convert the hardware source, registered by one clock, by inverting the input MSB (signed to offset binary) and taking the top PWM_BITS+4 bits.
REQ-016 SHALL run one shared free-running period counter cnt, PWM_BITS wide, wrapping from max to 0.
REQ-017 SHALL increment one shared phase counter ph (4 bits, wrapping 15 to 0) when cnt==max.
REQ-018 SHALL, when cnt==max, load each channel's active duty for the next period as coarse + ext, where ext = fine[3] if ph_next is odd, fine[2] if ph_next mod 4 == 2, fine[1] if ph_next mod 8 == 4, fine[0] if ph_next == 8, and 0 if ph_next == 0.
REQ-019 SHALL hold the active duty in PWM_BITS+1 bits; coarse = max with ext = 1 gives a fully-high period.
REQ-020 SHALL drive pwm_o[k] registered, high when cnt < active duty, giving one clock of latency from the counter.
REQ-021 SHALL let register writes, source changes and enable changes take effect only at the next period boundary, so the output is glitch-free.
REQ-022 SHALL load active duty 0 for a disabled channel, holding pwm_o[k] low from the next boundary.
REQ-023 SHALL, when a write and a boundary occur in the same cycle, use the new value for the period that starts.

Reset
REQ-024 SHALL, while rstn_i is low, asynchronously clear CTRL, all value registers, cnt, ph, active duties, pwm_o, sys_rdata, sys_ack and sys_err to 0.
REQ-025 SHALL start the first period with cnt=0 and ph=0 on the first clock after rstn_i deasserts.
REQ-026 SHALL have a reset mid-period abort that period, with no partial pulse after release.

Structure
REQ-027 SHALL place the address constants (CTRL, CH_BASE), the DITHER_BITS constant and the ext-selection function in package pwm_bank_pkg.
REQ-028 SHALL implement per-channel duty select, ext computation, the active-duty register and the comparator in sub-module red_pitaya_pwm_ch, instantiated NCH times via generate; the counters and bus logic SHALL stay in the top level.

Verification
REQ-029 SHALL cover: write 0x20=0x800 and CTRL=0x1 -> pwm_o[0] is high 128 of 256 clocks for every period after the next boundary.
REQ-030 SHALL cover: write 0x20=0x801 -> over 16 periods only the ph=8 period is 129 high, and total high is 2049 clocks per 4096.
REQ-031 SHALL cover: CTRL=0x10001 with pwm_i[13:0]=14'h2000 -> pwm_o[0] constantly low; with 14'h1FFF -> the ph=0 period is 255 high and the other 15 periods are fully high.
REQ-032 SHALL cover: write 0x20 while cnt=50 -> the current period is unchanged and the new duty applies from cnt=0.
REQ-033 SHALL cover: read 0x1000 and write 0x20+4*NCH -> sys_ack one cycle later, sys_rdata=0, sys_err=0, no register change.
REQ-034 SHALL cover: assert rstn_i mid-period with no clock edge -> pwm_o=0 immediately, and reading 0x20 after release returns 0.
